// File: rtl/dist_pkg.sv
// dist_pkg: shared types and helpers for the distribution node (sizing, saturation, round-robin pick)
package dist_pkg;
    localparam int MAX_CHILDREN = 32;
    localparam int IDX_W = 5;
    typedef logic [IDX_W-1:0] idx_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= m) ? v : v + 64'd1;
    endfunction
    function automatic idx_t rr_pick(input logic [MAX_CHILDREN-1:0] req, input idx_t ptr, input int n);
        idx_t g;
        logic hit;
        int k;
        g = '0;
        hit = 1'b0;
        for (int i = 0; i < MAX_CHILDREN; i++) begin
            k = (int'(ptr) + i) % n;
            if (i < n && !hit && req[k[IDX_W-1:0]]) begin
                g = idx_t'(k);
                hit = 1'b1;
            end
        end
        return g;
    endfunction
endpackage

// File: rtl/dist_fifo.sv
// dist_fifo: synchronous first-word-fall-through FIFO with full/empty flags and a flush input
module dist_fifo
    import dist_pkg::*;
#(
    parameter int WIDTH = 45,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0] r_wp, r_rp;
    logic w_push, w_pop;
    assign o_empty = r_wp == r_rp;
    assign o_full = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push = i_push && !o_full;
    assign w_pop = i_pop && !o_empty;
    assign o_dout = r_mem[r_rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/dist_node.sv
// dist_node: tree branch node buffering settings, dispatching them round-robin to idle children and collecting results
module dist_node
    import dist_pkg::*;
#(
    parameter int SETTING_WIDTH = 45,
    parameter int NUM_CHILDREN  = 4,
    parameter int IN_DEPTH      = 4,
    parameter int OUT_DEPTH     = 2,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_in_valid,
    input  logic [SETTING_WIDTH-1:0]              i_in_setting,
    output logic                                  o_in_ready,
    input  logic                                  i_abort,
    output logic                                  o_out_valid,
    output logic [SETTING_WIDTH-1:0]              o_out_setting,
    input  logic                                  i_out_rd_en,
    output logic                                  o_busy,
    output logic [NUM_CHILDREN-1:0]               o_child_start,
    output logic [SETTING_WIDTH-1:0]              o_child_setting,
    input  logic [NUM_CHILDREN-1:0]               i_child_idle,
    input  logic [NUM_CHILDREN-1:0]               i_child_success,
    output logic [NUM_CHILDREN-1:0]               o_child_rd_en,
    input  logic [NUM_CHILDREN*SETTING_WIDTH-1:0] i_child_setting_out,
    output logic                                  o_child_abort,
    output logic [CNT_WIDTH-1:0]                  o_dispatched_cnt,
    output logic [CNT_WIDTH-1:0]                  o_found_cnt
);
    localparam int SW = SETTING_WIDTH;
    localparam int NC = NUM_CHILDREN;
    logic w_in_full, w_in_empty, w_out_full, w_out_empty;
    logic [SW-1:0] w_in_head, w_out_head, w_col_data;
    logic [NC-1:0] r_start_pend, r_rd_pend, w_elig, w_rdy, w_start, w_rd;
    idx_t r_rr_disp, r_rr_col, w_dgnt, w_cgnt;
    logic w_run, w_do_start, w_do_col, w_push, w_pop_out;
    logic [CNT_WIDTH-1:0] r_disp_cnt, r_found_cnt;
    logic r_busy;
    always_comb begin
        w_run = !rst && !i_abort;
        w_elig = i_child_idle & ~r_start_pend;
        w_rdy = i_child_success & ~r_rd_pend;
        w_dgnt = rr_pick(MAX_CHILDREN'(w_elig), r_rr_disp, NC);
        w_cgnt = rr_pick(MAX_CHILDREN'(w_rdy), r_rr_col, NC);
        w_do_start = w_run && !w_in_empty && |w_elig;
        w_do_col = w_run && !w_out_full && |w_rdy;
        w_start = w_do_start ? NC'(1) << w_dgnt : '0;
        w_rd = w_do_col ? NC'(1) << w_cgnt : '0;
        w_col_data = i_child_setting_out[int'(w_cgnt)*SW +: SW];
        o_in_ready = w_run && !w_in_full;
        w_push = i_in_valid && o_in_ready;
        w_pop_out = w_run && i_out_rd_en && !w_out_empty;
        o_child_start = w_start;
        o_child_rd_en = w_rd;
        o_child_abort = !rst && i_abort;
        o_child_setting = rst ? '0 : w_in_head;
        o_out_setting = rst ? '0 : w_out_head;
        o_out_valid = !rst && !w_out_empty;
        o_busy = r_busy;
        o_dispatched_cnt = r_disp_cnt;
        o_found_cnt = r_found_cnt;
    end
    dist_fifo #(.WIDTH(SW), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk(clk), .rst(rst), .i_clr(i_abort), .i_push(w_push), .i_din(i_in_setting),
        .i_pop(w_do_start), .o_dout(w_in_head), .o_full(w_in_full), .o_empty(w_in_empty)
    );
    dist_fifo #(.WIDTH(SW), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk(clk), .rst(rst), .i_clr(i_abort), .i_push(w_do_col), .i_din(w_col_data),
        .i_pop(w_pop_out), .o_dout(w_out_head), .o_full(w_out_full), .o_empty(w_out_empty)
    );
    // Pend bits stop re-granting a child until its handshake line drops.
    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_start_pend <= '0;
            r_rd_pend <= '0;
            r_rr_disp <= '0;
            r_rr_col <= '0;
        end else begin
            r_start_pend <= (r_start_pend & i_child_idle) | w_start;
            r_rd_pend <= (r_rd_pend & i_child_success) | w_rd;
            if (w_do_start) r_rr_disp <= idx_t'((int'(w_dgnt) + 1) % NC);
            if (w_do_col) r_rr_col <= idx_t'((int'(w_cgnt) + 1) % NC);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_cnt <= '0;
            r_found_cnt <= '0;
            r_busy <= 1'b0;
        end else begin
            if (w_do_start) r_disp_cnt <= CNT_WIDTH'(sat_inc(64'(r_disp_cnt), CNT_WIDTH));
            if (w_do_col) r_found_cnt <= CNT_WIDTH'(sat_inc(64'(r_found_cnt), CNT_WIDTH));
            r_busy <= |(~i_child_idle) || |i_child_success || !w_in_empty || !w_out_empty;
        end
    end
endmodule
